// File: rtl/adc_in_pos_phs_ctrl.sv
// rtl/adc_in_pos_phs_ctrl.sv - ADC input IODELAY tap seek and sample-phase control
//
// Purpose: walks the ADC capture IODELAY one tap at a time toward the tap
// requested in reg_data, with a settle interval after every step. The
// requested sample-phase select is applied only once the tap has arrived.
// A 32-bit status word is published for software readback.
//
// Optional feature macro: ADC_IN_POS_PHS_RST_EN
//   defined   : a rising edge on reg_data[16] requests an IODELAY reset
//               (dly_rst pulse, tap position forced to 0, then re-seek)
//   undefined : reg_data[16] ignored, dly_rst tied low
//
// Ports:
//   user_clk    in   1   sole clock
//   user_rst    in   1   synchronous active-high reset
//   reg_data    in   32  [4:0] target tap, [9:8] phase select, [16] tap-reset request
//   dly_ce      out  1   IODELAY step enable (one-cycle pulse)
//   dly_inc     out  1   step direction, 1 = increment (valid with dly_ce)
//   dly_rst     out  1   IODELAY reset pulse
//   phs_sel     out  2   applied sample-phase select
//   busy        out  1   seek in progress
//   status_out  out  32  [4:0] cur_tap, [9:8] phs_sel, [23:16] step_cnt, [31] busy

`timescale 1ns/1ps

module adc_in_pos_phs_ctrl #(
  parameter int SETTLE_CYC = 16,
  parameter int TAP_W      = 5
) (
  input  logic        user_clk,
  input  logic        user_rst,
  input  logic [31:0] reg_data,
  output logic        dly_ce,
  output logic        dly_inc,
  output logic        dly_rst,
  output logic [1:0]  phs_sel,
  output logic        busy,
  output logic [31:0] status_out
);

  localparam logic [7:0]       SETTLE_LOAD = 8'(SETTLE_CYC - 1);
  localparam logic [TAP_W-1:0] TAP_ONE     = TAP_W'(1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CHECK  = 3'd1,
    S_STEP   = 3'd2,
`ifdef ADC_IN_POS_PHS_RST_EN
    S_RSTD   = 3'd4,
`endif
    S_SETTLE = 3'd3
  } state_t;

  state_t           state_q, state_d;
  logic [TAP_W-1:0] cur_tap_q, cur_tap_d;
  logic [7:0]       step_cnt_q, step_cnt_d;
  logic [7:0]       settle_q, settle_d;
  logic             dly_ce_q, dly_ce_d;
  logic             dly_inc_q, dly_inc_d;
  logic [1:0]       phs_q, phs_d;
  logic             busy_q, busy_d;
  logic [31:0]      status_q, status_d;

  logic [TAP_W-1:0] tgt_tap;
  logic [1:0]       tgt_phs;
  logic             tap_diff;
  logic             phs_diff;

  assign tgt_tap  = reg_data[TAP_W-1:0];
  assign tgt_phs  = reg_data[9:8];
  assign tap_diff = (tgt_tap != cur_tap_q);
  assign phs_diff = (tgt_phs != phs_q);

  logic unused_reg_bits;
  assign unused_reg_bits = ^{reg_data[31:10], reg_data[7:TAP_W]};

`ifdef ADC_IN_POS_PHS_RST_EN
  // Tap-reset request: rising edge of bit 16 latches a pending flag that is
  // held until the FSM reaches IDLE or CHECK and enters RSTD.
  logic rst_bit_q, rst_bit_d;
  logic pend_q, pend_d;
  logic dly_rst_q, dly_rst_d;

  always_comb begin
    rst_bit_d = reg_data[16];
    pend_d    = (pend_q && (state_q != S_RSTD)) || (reg_data[16] && !rst_bit_q);
    dly_rst_d = (state_d == S_RSTD);
  end

  always_ff @(posedge user_clk) begin
    if (user_rst) begin
      rst_bit_q <= 1'b0;
      pend_q    <= 1'b0;
      dly_rst_q <= 1'b0;
    end else begin
      rst_bit_q <= rst_bit_d;
      pend_q    <= pend_d;
      dly_rst_q <= dly_rst_d;
    end
  end

  assign dly_rst = dly_rst_q;
`else
  assign dly_rst = 1'b0;
`endif

  // State register
  always_ff @(posedge user_clk) begin
    if (user_rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; a pending tap reset overrides any other transition
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (tap_diff || phs_diff) state_d = S_CHECK;
`ifdef ADC_IN_POS_PHS_RST_EN
        if (pend_q) state_d = S_RSTD;
`endif
      end
      S_CHECK: begin
        if (tap_diff) state_d = S_STEP;
        else          state_d = S_IDLE;
`ifdef ADC_IN_POS_PHS_RST_EN
        if (pend_q) state_d = S_RSTD;
`endif
      end
      S_STEP: state_d = S_SETTLE;
      S_SETTLE: begin
        if (settle_q == 8'd0) state_d = S_CHECK;
      end
`ifdef ADC_IN_POS_PHS_RST_EN
      S_RSTD: state_d = S_SETTLE;
`endif
      default: state_d = S_IDLE;
    endcase
  end

  // Output and datapath next values. Pulses are derived from state_d so the
  // registered outputs line up with the state they belong to.
  always_comb begin
    cur_tap_d  = cur_tap_q;
    step_cnt_d = step_cnt_q;
    settle_d   = settle_q;
    dly_inc_d  = dly_inc_q;
    phs_d      = phs_q;
    dly_ce_d   = (state_d == S_STEP);
    busy_d     = (state_d != S_IDLE);

    case (state_q)
      S_CHECK: begin
        // Direction is fixed when the target is sampled; the STEP that
        // follows moves cur_tap by one toward it, so it never wraps.
        if (state_d == S_STEP) dly_inc_d = (tgt_tap > cur_tap_q);
        if (state_d == S_IDLE) phs_d = tgt_phs;
      end
      S_STEP: begin
        cur_tap_d  = dly_inc_q ? (cur_tap_q + TAP_ONE) : (cur_tap_q - TAP_ONE);
        step_cnt_d = step_cnt_q + 8'd1;
        settle_d   = SETTLE_LOAD;
      end
      S_SETTLE: begin
        if (settle_q != 8'd0) settle_d = settle_q - 8'd1;
      end
`ifdef ADC_IN_POS_PHS_RST_EN
      S_RSTD: begin
        cur_tap_d = '0;
        settle_d  = SETTLE_LOAD;
      end
`endif
      default: ;
    endcase

    // Status is built from the registered state, hence one cycle behind it
    status_d = {busy_q, 7'd0, step_cnt_q, 6'd0, phs_q, 3'd0, 5'(cur_tap_q)};
  end

  always_ff @(posedge user_clk) begin
    if (user_rst) begin
      cur_tap_q  <= '0;
      step_cnt_q <= '0;
      settle_q   <= '0;
      dly_ce_q   <= 1'b0;
      dly_inc_q  <= 1'b0;
      phs_q      <= '0;
      busy_q     <= 1'b0;
      status_q   <= '0;
    end else begin
      cur_tap_q  <= cur_tap_d;
      step_cnt_q <= step_cnt_d;
      settle_q   <= settle_d;
      dly_ce_q   <= dly_ce_d;
      dly_inc_q  <= dly_inc_d;
      phs_q      <= phs_d;
      busy_q     <= busy_d;
      status_q   <= status_d;
    end
  end

  assign dly_ce     = dly_ce_q;
  assign dly_inc    = dly_inc_q;
  assign phs_sel    = phs_q;
  assign busy       = busy_q;
  assign status_out = status_q;

endmodule

// File: tb/tb_adc_in_pos_phs_ctrl.sv
// tb/tb_adc_in_pos_phs_ctrl.sv - self-checking bench for adc_in_pos_phs_ctrl

`timescale 1ns/1ps

module tb_adc_in_pos_phs_ctrl;

  localparam int S = 16;

  logic        clk = 1'b0;
  logic        user_rst;
  logic [31:0] reg_data;
  logic        dly_ce, dly_inc, dly_rst, busy;
  logic [1:0]  phs_sel;
  logic [31:0] status_out;

  int errors = 0;
  int checks = 0;

  // reference model state
  int m_tap, m_phs, m_step;
  bit m_b16;

  // expected trace
  string       e_ce, e_rst;
  int          e_bfirst, e_blast, e_phschg, e_ncyc, e_chg;
  logic [31:0] e_status;

  // observed trace
  string       o_ce, o_rst;
  int          o_bfirst, o_blast, o_phschg;
  logic [31:0] o_status;

  always #5 clk = ~clk;

  adc_in_pos_phs_ctrl #(.SETTLE_CYC(S), .TAP_W(5)) dut (
    .user_clk  (clk),
    .user_rst  (user_rst),
    .reg_data  (reg_data),
    .dly_ce    (dly_ce),
    .dly_inc   (dly_inc),
    .dly_rst   (dly_rst),
    .phs_sel   (phs_sel),
    .busy      (busy),
    .status_out(status_out)
  );

  function automatic logic [31:0] st_word(int tap, int phs, int step);
    return {1'b0, 7'd0, 8'(step), 6'd0, 2'(phs), 3'd0, 5'(tap)};
  endfunction

  // Step-level model: the target is read at each CHECK; CHECKs are spaced
  // S+2 apart, each step's pulse lands the cycle after its CHECK.
  task automatic predict(input logic [31:0] w, input int chg, input logic [31:0] cv);
    bit          rq;
    int          chk;
    logic [31:0] t;
    e_ce = ""; e_rst = "";
    e_bfirst = -1; e_blast = -1; e_phschg = -1;
`ifdef ADC_IN_POS_PHS_RST_EN
    rq = w[16] && !m_b16;
    m_b16 = w[16];
`else
    rq = 1'b0;
`endif
    if (int'(w[4:0]) != m_tap || int'(w[9:8]) != m_phs || rq) begin
      if (rq) begin
        e_rst = "2 ";
        m_tap = 0;
        chk = 3 + S;
        e_bfirst = 2;
      end else begin
        chk = 1;
        e_bfirst = 1;
      end
      t = (chg >= 0 && chk >= chg) ? cv : w;
      while (int'(t[4:0]) != m_tap) begin
        if (int'(t[4:0]) > m_tap) begin
          e_ce = {e_ce, $sformatf("%0d+ ", chk + 1)};
          m_tap = m_tap + 1;
        end else begin
          e_ce = {e_ce, $sformatf("%0d- ", chk + 1)};
          m_tap = m_tap - 1;
        end
        m_step = (m_step + 1) % 256;
        chk = chk + S + 2;
        t = (chg >= 0 && chk >= chg) ? cv : w;
      end
      e_blast = chk;
      if (int'(t[9:8]) != m_phs) e_phschg = chk + 1;
      m_phs = int'(t[9:8]);
    end
    e_chg    = (chg >= 0 && chg <= e_blast) ? chg : -1;
    e_ncyc   = (e_blast < 0) ? 30 : e_blast + 4;
    e_status = st_word(m_tap, m_phs, m_step);
  endtask

  // Called at cycle-0 sample point (#1 after an edge); returns at the same
  // phase of the cycle following the last sample.
  task automatic capture(input logic [31:0] w, input int chg, input logic [31:0] cv, input int n);
    logic [1:0] p0;
    p0 = phs_sel;
    o_ce = ""; o_rst = "";
    o_bfirst = -1; o_blast = -1; o_phschg = -1;
    reg_data = w;
    for (int c = 0; c < n; c++) begin
      if (c == chg) reg_data = cv;
      if (dly_ce === 1'b1) o_ce = {o_ce, $sformatf("%0d%s ", c, (dly_inc === 1'b1) ? "+" : "-")};
      if (dly_rst === 1'b1) o_rst = {o_rst, $sformatf("%0d ", c)};
      if (busy === 1'b1) begin
        if (o_bfirst < 0) o_bfirst = c;
        o_blast = c;
      end
      if (phs_sel !== p0 && o_phschg < 0) o_phschg = c;
      o_status = status_out;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    user_rst = 1'b1;
    reg_data = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    user_rst = 1'b0;
    checks++;
    if ({dly_ce, dly_inc, dly_rst, busy, phs_sel} !== 6'd0) begin
      errors++;
      $display("FAIL reset_outputs got=%b want=000000", {dly_ce, dly_inc, dly_rst, busy, phs_sel});
    end
    checks++;
    if (status_out !== 32'h0) begin
      errors++;
      $display("FAIL reset_status got=%h want=00000000", status_out);
    end
  endtask

  task automatic test_seek(input string name, input logic [31:0] w, input int chg, input logic [31:0] cv);
    predict(w, chg, cv);
    capture(w, e_chg, cv, e_ncyc);
    checks++;
    if (o_ce != e_ce) begin
      errors++;
      $display("FAIL %s ce_trace got='%s' want='%s'", name, o_ce, e_ce);
    end
    checks++;
    if (o_rst != e_rst) begin
      errors++;
      $display("FAIL %s rst_trace got='%s' want='%s'", name, o_rst, e_rst);
    end
    checks++;
    if (o_bfirst != e_bfirst) begin
      errors++;
      $display("FAIL %s busy_rise got=%0d want=%0d", name, o_bfirst, e_bfirst);
    end
    checks++;
    if (o_blast != e_blast) begin
      errors++;
      $display("FAIL %s busy_last got=%0d want=%0d", name, o_blast, e_blast);
    end
    checks++;
    if (o_phschg != e_phschg) begin
      errors++;
      $display("FAIL %s phs_change got=%0d want=%0d", name, o_phschg, e_phschg);
    end
    checks++;
    if (o_status !== e_status) begin
      errors++;
      $display("FAIL %s status got=%h want=%h", name, o_status, e_status);
    end
  endtask

  // Reset asserted mid-SETTLE after two decrements from the current tap
  task automatic test_reset_mid();
    int nce;
    int exp_tap;
    nce = 0;
    exp_tap = m_tap - 2;
    reg_data = {22'd0, 2'(m_phs), 8'd0};
    for (int c = 0; c < 25; c++) begin
      if (dly_ce === 1'b1) nce++;
      @(posedge clk); #1;
    end
    checks++;
    if (nce != 2) begin
      errors++;
      $display("FAIL reset_mid ce_count got=%0d want=2", nce);
    end
    checks++;
    if (status_out[31] !== 1'b1 || int'(status_out[4:0]) != exp_tap) begin
      errors++;
      $display("FAIL reset_mid pre_status got=%h want busy=1 tap=%0d", status_out, exp_tap);
    end
    user_rst = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid busy got=%b want=0", busy);
    end
    checks++;
    if (status_out !== 32'h0) begin
      errors++;
      $display("FAIL reset_mid status got=%h want=00000000", status_out);
    end
    checks++;
    if ({dly_ce, dly_rst, phs_sel} !== 4'd0) begin
      errors++;
      $display("FAIL reset_mid pulses got=%b want=0000", {dly_ce, dly_rst, phs_sel});
    end
    reg_data = 32'h0;
    user_rst = 1'b0;
    m_tap = 0; m_phs = 0; m_step = 0; m_b16 = 1'b0;
  endtask

  task automatic test_random(input int n);
    logic [31:0] w, cv;
    int          chg;
    for (int i = 0; i < n; i++) begin
      w  = $urandom & 32'hFFFE_FFFF;
      cv = $urandom & 32'hFFFE_FFFF;
      chg = ($urandom_range(0, 1) == 1) ? int'($urandom_range(3, 80)) : -1;
      test_seek($sformatf("random%0d", i), w, chg, cv);
    end
  endtask

  initial begin
    user_rst = 1'b1;
    reg_data = 32'h0;
    m_tap = 0; m_phs = 0; m_step = 0; m_b16 = 1'b0;
    test_reset();
    test_seek("idle_zero", 32'h0000_0000, -1, 32'h0);
    test_seek("seek_up3", 32'h0000_0003, -1, 32'h0);
    test_seek("down_phase3", 32'h0000_0301, -1, 32'h0);
    test_seek("phase_only", 32'h0000_0101, -1, 32'h0);
    test_seek("to_zero", 32'h0000_0000, -1, 32'h0);
    test_seek("redirect", 32'h0000_000A, 45, 32'h0000_0002);
    test_seek("seek_7", 32'h0000_0007, -1, 32'h0);
    test_seek("rst_req", 32'h0001_0007, -1, 32'h0);
    test_seek("rst_clear", 32'h0000_0007, -1, 32'h0);
    test_reset_mid();
    test_seek("post_reset", 32'h0000_0000, -1, 32'h0);
    test_random(8);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog timeout errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end

endmodule
